// File: rtl/d_sram_to_sram_like_if.sv
// SRAM-like bus between the data-side bridge (master) and the memory/cache (slave).
interface d_sram_to_sram_like_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_addr_ok;
  logic        data_data_ok;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_rdata, data_addr_ok, data_data_ok
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_rdata, data_addr_ok, data_data_ok
  );
endinterface

// File: rtl/d_sram_to_sram_like.sv
// Bridges the CPU's single-cycle data SRAM port onto a split addr_ok/data_ok
// SRAM-like bus, stalling the pipeline until each access completes.
module d_sram_to_sram_like #(
  parameter bit ALIGN_READS = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          data_sram_en,
  input  logic [3:0]                    data_sram_wen,
  input  logic [31:0]                   data_sram_addr,
  input  logic [31:0]                   data_sram_wdata,
  output logic [31:0]                   data_sram_rdata,
  output logic                          d_stall,
  input  logic                          longest_stall,
  d_sram_to_sram_like_if.master         bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    HOLD      = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [31:0] rdata_r;
  logic        resp_s;

  function automatic logic [1:0] size_of_wen(input logic [3:0] wen);
    logic [1:0] size;
    case (wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size = 2'd0;
      4'b0011, 4'b1100:                   size = 2'd1;
      default:                            size = 2'd2;
    endcase
    return size;
  endfunction

  // The response only counts while an access is outstanding; stray data_ok is dropped.
  assign resp_s = (state_r == WAIT_DATA) && bus.data_data_ok;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.data_req && bus.data_addr_ok) begin
          state_s = WAIT_DATA;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT_DATA: begin
        if (bus.data_data_ok) begin
          state_s = longest_stall ? HOLD : IDLE;
        end else begin
          state_s = WAIT_DATA;
        end
      end
      HOLD: begin
        if (!longest_stall) begin
          state_s = IDLE;
        end else begin
          state_s = HOLD;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Keep the returned word for the CPU while the pipeline is frozen in HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_r <= 32'h0000_0000;
    end else if (resp_s) begin
      rdata_r <= bus.data_rdata;
    end else begin
      rdata_r <= rdata_r;
    end
  end

  // Request side: combinational so a request goes out in the same cycle en rises.
  always_comb begin
    bus.data_req   = data_sram_en && (state_r == IDLE);
    bus.data_wr    = |data_sram_wen;
    bus.data_wdata = data_sram_wdata;
    if (bus.data_wr) begin
      bus.data_size = size_of_wen(data_sram_wen);
      bus.data_addr = data_sram_addr;
    end else begin
      bus.data_size = 2'd2;
      bus.data_addr = ALIGN_READS ? {data_sram_addr[31:2], 2'b00} : data_sram_addr;
    end
  end

  // CPU side: release the stall in the data_ok cycle and forward the data directly.
  always_comb begin
    d_stall         = data_sram_en &&
                      ((state_r == IDLE) || ((state_r == WAIT_DATA) && !bus.data_data_ok));
    data_sram_rdata = resp_s ? bus.data_rdata : rdata_r;
  end

endmodule
